// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - shared constants, puncture tables and FSM states for the K=7 encoder scheduler
package conv_enc_pkg;

    localparam logic [1:0] RATE_1_2  = 2'b00;
    localparam logic [1:0] RATE_2_3  = 2'b01;
    localparam logic [1:0] RATE_3_4  = 2'b10;
    localparam logic [1:0] RATE_RSVD = 2'b11;

    // Generator taps over {b, d1, d2, d3, d4, d5, d6}, b in the MSB
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    localparam int TAIL_LEN = 6;

    // Keep masks as {keep_a, keep_b}
    localparam logic [1:0] KEEP_AB = 2'b11;
    localparam logic [1:0] KEEP_A  = 2'b10;
    localparam logic [1:0] KEEP_B  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DRAIN
    } state_t;

    // Number of coded pairs in one puncture period
    function automatic logic [1:0] punct_period(input logic [1:0] rate);
        case (rate)
            RATE_2_3: punct_period = 2'd2;
            RATE_3_4: punct_period = 2'd3;
            default:  punct_period = 2'd1;
        endcase
    endfunction

    // Which half of the coded pair survives puncturing at a given phase
    function automatic logic [1:0] punct_keep(input logic [1:0] rate, input logic [1:0] phase);
        punct_keep = KEEP_AB;
        case (rate)
            RATE_2_3: if (phase == 2'd1) punct_keep = KEEP_A;
            RATE_3_4: begin
                if (phase == 2'd1) punct_keep = KEEP_A;
                if (phase == 2'd2) punct_keep = KEEP_B;
            end
            default: punct_keep = KEEP_AB;
        endcase
    endfunction

endpackage

// File: rtl/conv_k7_core.sv
// rtl/conv_k7_core.sv - rate-1/2 K=7 convolutional encoder core with step enable and sync clear
module conv_k7_core (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic code_a,
    output logic code_b
);
    import conv_enc_pkg::*;

    // sr[5] is d1 (newest), sr[0] is d6 (oldest)
    logic [5:0] sr;
    logic [6:0] taps;

    assign taps   = {bit_in, sr};
    assign code_a = ^(taps & G0);
    assign code_b = ^(taps & G1);

    // Shift the new bit in as d1 on every step; clear starts a fresh frame from zero state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= {bit_in, sr[5:1]};
        end
    end

endmodule

// File: rtl/conv_enc_sched.sv
// rtl/conv_enc_sched.sv - frame controller: data/tail stepping, puncturing and bit serialisation
module conv_enc_sched #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       rate,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import conv_enc_pkg::*;

    state_t           state;
    logic [1:0]       rate_r;
    logic [1:0]       phase;
    logic [LEN_W-1:0] remaining;
    logic [2:0]       tail_cnt;

    logic buf_full, buf_a, buf_b, keep_a, keep_b;
    logic core_a, core_b, core_in;
    logic hs, pair_done, load, step, accept_start;

    // The pair buffer refills as soon as its last surviving bit leaves, keeping 1 bit/cycle out
    assign hs           = buf_full && out_ready;
    assign pair_done    = hs && !(keep_a && keep_b);
    assign load         = !buf_full || pair_done;
    assign step         = load && (((state == ST_DATA) && in_valid) || (state == ST_TAIL));
    assign in_ready     = (state == ST_DATA) && load;
    assign core_in      = (state == ST_DATA) ? in_bit : 1'b0;
    assign accept_start = (state == ST_IDLE) && start && (rate != RATE_RSVD);
    assign out_valid    = buf_full;
    assign out_bit      = keep_a ? buf_a : buf_b;

    conv_k7_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_start),
        .en     (step),
        .bit_in (core_in),
        .code_a (core_a),
        .code_b (core_b)
    );

    // Frame sequencing: capture, count data bits, count tail bits, wait for the buffer to drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rate_r    <= RATE_1_2;
            phase     <= '0;
            remaining <= '0;
            tail_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (step) begin
                phase <= (phase == punct_period(rate_r) - 2'd1) ? 2'd0 : phase + 2'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (rate == RATE_RSVD) begin
                            err <= 1'b1;
                        end else begin
                            rate_r    <= rate;
                            remaining <= frame_len;
                            tail_cnt  <= '0;
                            phase     <= '0;
                            busy      <= 1'b1;
                            state     <= (frame_len == '0) ? ST_TAIL : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (step) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (step) begin
                        tail_cnt <= tail_cnt + 3'd1;
                        if (tail_cnt == 3'(TAIL_LEN - 1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!buf_full || pair_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pair buffer: load a fresh punctured pair on each core step, retire A then B
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= 1'b0;
            buf_a    <= 1'b0;
            buf_b    <= 1'b0;
            keep_a   <= 1'b0;
            keep_b   <= 1'b0;
        end else if (step) begin
            buf_full         <= 1'b1;
            buf_a            <= core_a;
            buf_b            <= core_b;
            {keep_a, keep_b} <= punct_keep(rate_r, phase);
        end else if (pair_done) begin
            buf_full <= 1'b0;
            buf_a    <= 1'b0;
            buf_b    <= 1'b0;
            keep_a   <= 1'b0;
            keep_b   <= 1'b0;
        end else if (hs) begin
            keep_a <= 1'b0;
        end
    end

endmodule
